// File: rtl/imem_loader.sv
// Byte-stream program loader: parses HDR/LEN/words/CSUM frames into instruction
// memory writes and holds the CPU in reset until a frame's checksum verifies.
module imem_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic [8:0]        r_count;
  logic [7:0]        r_hi;
  logic [7:0]        r_acc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_imemAddr;
  logic [15:0]       r_wdata;
  logic              r_we;
  logic              r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HUNT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    in_ready     = (r_state != S_DONE);
    w_accept     = in_valid && in_ready;
    done         = (r_state == S_DONE);
    cpu_rst_hold = (r_state != S_DONE);
    case (r_state)
      S_HUNT: if (w_accept && in_data == HDR_BYTE) w_next = S_LEN;
      S_LEN:  if (w_accept) w_next = S_HI;
      S_HI:   if (w_accept) w_next = S_LO;
      S_LO:   if (w_accept) w_next = (r_count == 9'd1) ? S_CSUM : S_HI;
      S_CSUM: if (w_accept) w_next = (in_data == r_acc) ? S_DONE : S_HUNT;
      S_DONE: if (start) w_next = S_HUNT;
      default: w_next = S_HUNT;
    endcase
  end

  // The write is registered so the word lands one cycle after its low byte,
  // letting the byte stream run back-to-back without ever dropping in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_hi       <= '0;
      r_acc      <= '0;
      r_addr     <= '0;
      r_imemAddr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_HUNT: begin
            if (in_data == HDR_BYTE) begin
              r_err  <= 1'b0;
              r_addr <= '0;
            end
          end
          S_LEN: begin
            r_count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            r_acc   <= in_data;
          end
          S_HI: begin
            r_hi  <= in_data;
            r_acc <= r_acc ^ in_data;
          end
          S_LO: begin
            r_acc      <= r_acc ^ in_data;
            r_we       <= 1'b1;
            r_wdata    <= {r_hi, in_data};
            r_imemAddr <= r_addr;
            r_addr     <= r_addr + 1'b1;
            r_count    <= r_count - 9'd1;
          end
          S_CSUM: begin
            if (in_data != r_acc) r_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_imemAddr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of byte vectors with hand-computed
// outputs, plus sequences for the 256-word wrap frame and an async reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        startIn = 1'b0;
  logic        imemWe;
  logic [7:0]  imemAddr;
  logic [15:0] imemWdata;
  logic        cpuRstHold;
  logic        doneOut;
  logic        errOut;

  int nApplied = 0;
  int nFail    = 0;
  int weCount  = 0;
  logic [15:0] mem [256];

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        start;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  imem_loader #(.ADDR_W(8), .HDR_BYTE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(inData),
    .in_valid(inValid),
    .in_ready(inReady),
    .start(startIn),
    .imem_we(imemWe),
    .imem_addr(imemAddr),
    .imem_wdata(imemWdata),
    .cpu_rst_hold(cpuRstHold),
    .done(doneOut),
    .err(errOut)
  );

  always #5 clk = ~clk;

  // Memory model and write-pulse counter fed from the write port.
  always @(posedge clk) begin
    if (imemWe === 1'b1) begin
      mem[imemAddr] = imemWdata;
      weCount++;
    end
  end

  function automatic void addVec(input logic [7:0] d, input logic v, input logic s,
                                 input logic rdy, input logic we, input logic [7:0] a,
                                 input logic [15:0] wd, input logic h, input logic dn,
                                 input logic e);
    vec_t x;
    x.data = d; x.valid = v; x.start = s; x.rdy = rdy; x.we = we; x.addr = a;
    x.wd = wd; x.hold = h; x.done = dn; x.err = e;
    vecs.push_back(x);
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic s);
    inData  = d;
    inValid = v;
    startIn = s;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    startIn = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic rdy, input logic we,
                             input logic [7:0] a, input logic [15:0] wd,
                             input logic h, input logic dn, input logic e);
    nApplied++;
    if (inReady !== rdy || imemWe !== we || imemAddr !== a || imemWdata !== wd ||
        cpuRstHold !== h || doneOut !== dn || errOut !== e) begin
      nFail++;
      $display("[TB] FAIL %s: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, required rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b",
               name, inReady, imemWe, imemAddr, imemWdata, cpuRstHold, doneOut, errOut,
               rdy, we, a, wd, h, dn, e);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int required);
    nApplied++;
    if (actual != required) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  initial begin
    logic [7:0]  csum;
    logic [15:0] w;
    int          bad;

    // Good frame, DONE ignoring bytes, start, bad checksum, garbage + good frame,
    // then a frame with header values as data and a start pulse mid-frame.
    addVec(8'hA5,1,0, 1,0,8'h00,16'h0000,1,0,0);
    addVec(8'h02,1,0, 1,0,8'h00,16'h0000,1,0,0);
    addVec(8'h40,1,0, 1,0,8'h00,16'h0000,1,0,0);
    addVec(8'h12,1,0, 1,1,8'h00,16'h4012,1,0,0);
    addVec(8'h00,1,0, 1,0,8'h00,16'h4012,1,0,0);
    addVec(8'h34,1,0, 1,1,8'h01,16'h0034,1,0,0);
    addVec(8'h64,1,0, 0,0,8'h01,16'h0034,0,1,0);
    addVec(8'h55,1,0, 0,0,8'h01,16'h0034,0,1,0);
    addVec(8'hA5,1,0, 0,0,8'h01,16'h0034,0,1,0);
    addVec(8'h00,0,1, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'hA5,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h02,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h40,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h12,1,0, 1,1,8'h00,16'h4012,1,0,0);
    addVec(8'h00,1,0, 1,0,8'h00,16'h4012,1,0,0);
    addVec(8'h34,1,0, 1,1,8'h01,16'h0034,1,0,0);
    addVec(8'h00,1,0, 1,0,8'h01,16'h0034,1,0,1);
    addVec(8'h00,0,0, 1,0,8'h01,16'h0034,1,0,1);
    addVec(8'h11,1,0, 1,0,8'h01,16'h0034,1,0,1);
    addVec(8'h22,1,0, 1,0,8'h01,16'h0034,1,0,1);
    addVec(8'hA5,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h01,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h70,1,0, 1,0,8'h01,16'h0034,1,0,0);
    addVec(8'h00,1,0, 1,1,8'h00,16'h7000,1,0,0);
    addVec(8'h71,1,0, 0,0,8'h00,16'h7000,0,1,0);
    addVec(8'h00,0,1, 1,0,8'h00,16'h7000,1,0,0);
    addVec(8'hA5,1,0, 1,0,8'h00,16'h7000,1,0,0);
    addVec(8'h01,1,1, 1,0,8'h00,16'h7000,1,0,0);
    addVec(8'hA5,1,0, 1,0,8'h00,16'h7000,1,0,0);
    addVec(8'hA5,1,0, 1,1,8'h00,16'hA5A5,1,0,0);
    addVec(8'h01,1,0, 0,0,8'h00,16'hA5A5,0,1,0);

    #1;
    checkOutput("reset_state", 1,0,8'h00,16'h0000,1,0,0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].valid, vecs[i].start);
      checkOutput($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr,
                  vecs[i].wd, vecs[i].hold, vecs[i].done, vecs[i].err);
    end

    // 256-word frame (LEN=0): address wraps, exactly 256 write pulses.
    applyStimulus(8'h00, 1'b0, 1'b1);
    weCount = 0;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], i[7:0] ^ 8'h3C};
      csum = csum ^ w[15:8] ^ w[7:0];
      applyStimulus(w[15:8], 1'b1, 1'b0);
      applyStimulus(w[7:0], 1'b1, 1'b0);
      checkOutput($sformatf("wrap_word%0d", i), 1,1,i[7:0],w,1,0,0);
    end
    applyStimulus(csum, 1'b1, 1'b0);
    checkOutput("wrap_csum", 0,0,8'hFF,{8'hFF, 8'hFF ^ 8'h3C},0,1,0);
    checkInt("wrap_we_count", weCount, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], i[7:0] ^ 8'h3C};
      if (mem[i] !== w) bad++;
    end
    checkInt("wrap_mem_bad_words", bad, 0);

    // Async reset after a HI byte, with no clock edge, then a clean reload.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h40, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 1,0,8'h00,16'h0000,1,0,0);
    #2;
    rst = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0);
    checkOutput("reload_write", 1,1,8'h00,16'h1234,1,0,0);
    applyStimulus(8'h27, 1'b1, 1'b0);
    checkOutput("reload_done", 0,0,8'h00,16'h1234,0,1,0);
    checkInt("reload_mem0", int'(mem[0]), 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
